// File: rtl/ring_transmitter_queue.sv
// Ring-node transmit queue: FIFO, shortest-path routing, spaced send strobes.
// Optional TX_HOLD_EN adds neighbour back-pressure (hold_r/hold_l).
module ring_transmitter_queue #(
  parameter int NODE_ID   = 0,
  parameter int NUM_NODES = 8,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     new_sig,
  input  logic [31:0]              in_sig,
`ifdef TX_HOLD_EN
  input  logic                     hold_r,
  input  logic                     hold_l,
`endif
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [31:0]              out_sig,
  output logic                     send_r,
  output logic                     send_l,
  output logic                     send_s,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] LP_N    = 5'(NUM_NODES);
  localparam logic [4:0] LP_OFS  = 5'(NUM_NODES - NODE_ID);
  localparam logic [4:0] LP_HALF = 5'(NUM_NODES / 2);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t r_state, w_state_n;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [31:0]   r_out;
  logic          r_sr, r_sl, r_ss;
  logic [7:0]    r_drop;

  logic [31:0] w_head;
  logic [3:0]  w_dest;
  logic [4:0]  w_sum;
  logic [4:0]  w_diff;
  logic        w_valid;
  logic        w_self;
  logic        w_right;
  logic        w_left;
  logic        w_hold;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_sr_n, w_sl_n, w_ss_n;

  assign w_head  = r_mem[r_rd];
  assign w_dest  = w_head[31:28];
  assign w_sum   = {1'b0, w_dest} + LP_OFS;
  assign w_diff  = (w_sum >= LP_N) ? (w_sum - LP_N) : w_sum;
  assign w_valid = ({1'b0, w_dest} < LP_N);
  assign w_self  = (w_diff == 5'd0);
  assign w_right = !w_self && (w_diff <= LP_HALF);
  assign w_left  = !w_self && !w_right;

`ifdef TX_HOLD_EN
  assign w_hold = w_valid &&
                  ((w_right && hold_r) || (w_left && hold_l));
`else
  assign w_hold = 1'b0;
`endif

  assign w_full = (r_count == LP_DEPTH);
  assign w_push = new_sig && !w_full;

  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    w_drop    = 1'b0;
    w_sr_n    = 1'b0;
    w_sl_n    = 1'b0;
    w_ss_n    = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_count != '0) && !w_hold) begin
          w_pop = 1'b1;
          if (w_valid) begin
            w_state_n = SEND;
            unique case (1'b1)
              w_self:  w_ss_n = 1'b1;
              w_right: w_sr_n = 1'b1;
              default: w_sl_n = 1'b1;
            endcase
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      SEND:    w_state_n = GAP;
      GAP:     w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_out   <= '0;
      r_sr    <= 1'b0;
      r_sl    <= 1'b0;
      r_ss    <= 1'b0;
      r_drop  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_state_n;
      r_ovf   <= new_sig && w_full;
      r_sr    <= w_sr_n;
      r_sl    <= w_sl_n;
      r_ss    <= w_ss_n;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_mem[r_wr] <= in_sig;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_pop && w_valid) r_out <= w_head;
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign out_sig  = r_out;
  assign send_r   = r_sr;
  assign send_l   = r_sl;
  assign send_s   = r_ss;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_ring_transmitter_queue.sv
// Bench for ring_transmitter_queue: route table, scoreboard, corner sequences.
// Build with +define+TX_HOLD_EN to also exercise neighbour hold.
module tb_ring_transmitter_queue;

  localparam int NID = 2;
  localparam int NN  = 8;
  localparam int DP  = 4;

  localparam logic [1:0] RT_R = 2'd1;
  localparam logic [1:0] RT_L = 2'd2;
  localparam logic [1:0] RT_S = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_sig = 1'b0;
  logic [31:0] in_sig = '0;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic [31:0] out_sig;
  logic        send_r, send_l, send_s;
  logic [7:0]  drop_cnt;
`ifdef TX_HOLD_EN
  logic        hold_r = 1'b0;
  logic        hold_l = 1'b0;
`endif

  ring_transmitter_queue #(
    .NODE_ID(NID), .NUM_NODES(NN), .DEPTH(DP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .new_sig(new_sig), .in_sig(in_sig),
`ifdef TX_HOLD_EN
    .hold_r(hold_r), .hold_l(hold_l),
`endif
    .full(full), .count(count), .overflow(overflow),
    .out_sig(out_sig),
    .send_r(send_r), .send_l(send_l), .send_s(send_s),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  rt;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  rt;
    logic        inv;
  } vec_t;

  exp_t sb[$];
  int   strobe_cyc[$];
  int   cyc = 0;
  int   peak = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_drop = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest expected send.
  always @(negedge clk) begin
    if (32'(count) > peak) peak = 32'(count);
    if (rst_n && (send_r || send_l || send_s)) begin
      logic [1:0] rt;
      exp_t e;
      strobe_cyc.push_back(cyc);
      chk("onehot", 32'(send_r) + 32'(send_l) + 32'(send_s), 32'd1);
      rt = send_r ? RT_R : (send_l ? RT_L : RT_S);
      if (sb.size() == 0) begin
        chk("unexpected_send", out_sig, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_data", out_sig, e.d);
        chk("sb_route", 32'(rt), 32'(e.rt));
      end
    end
  end

  task automatic drive_push(input logic [31:0] d);
    new_sig = 1'b1;
    in_sig  = d;
    @(negedge clk);
    new_sig = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && count == 0) done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: got sb=%0d count=%0d want 0",
               sb.size(), count);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{32'h2200_0010, RT_S, 1'b0};
    vt[1]  = '{32'h3200_0011, RT_R, 1'b0};
    vt[2]  = '{32'h4200_0012, RT_R, 1'b0};
    vt[3]  = '{32'h5200_0013, RT_R, 1'b0};
    vt[4]  = '{32'h6200_0014, RT_R, 1'b0};
    vt[5]  = '{32'h7200_0015, RT_L, 1'b0};
    vt[6]  = '{32'h0200_0016, RT_L, 1'b0};
    vt[7]  = '{32'h1200_0017, RT_L, 1'b0};
    vt[8]  = '{32'h8200_0018, RT_R, 1'b1};
    vt[9]  = '{32'hF200_0019, RT_R, 1'b1};
    vt[10] = '{32'hA200_001A, RT_R, 1'b1};
    vt[11] = '{32'h4200_FFFF, RT_R, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out", out_sig, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_strobes", {29'd0, send_r, send_l, send_s}, 32'd0);
    chk("idle_flags", {29'd0, full, overflow, 1'b0}, 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_out", out_sig, 32'd0);
    chk("idle_drop", 32'(drop_cnt), 32'd0);

    // Single send latency.
    sb.push_back('{32'h5200_002A, RT_R});
    new_sig = 1'b1;
    in_sig  = 32'h5200_002A;
    @(negedge clk);
    new_sig = 1'b0;
    chk("lat_e0_send", 32'(send_r), 32'd0);
    chk("lat_e0_count", 32'(count), 32'd1);
    @(negedge clk);
    chk("lat_e1_send_r", 32'(send_r), 32'd1);
    chk("lat_e1_other", {30'd0, send_l, send_s}, 32'd0);
    chk("lat_e1_out", out_sig, 32'h5200_002A);
    @(negedge clk);
    chk("lat_e2_send_r", 32'(send_r), 32'd0);
    chk("lat_e2_out_held", out_sig, 32'h5200_002A);
    drain();

    // Three back-to-back pushes, left / right tie / self.
    strobe_cyc.delete();
    peak = 0;
    sb.push_back('{32'h7200_004D, RT_L});
    sb.push_back('{32'h6200_0059, RT_R});
    sb.push_back('{32'h2200_0001, RT_S});
    new_sig = 1'b1;
    in_sig = 32'h7200_004D; @(negedge clk);
    in_sig = 32'h6200_0059; @(negedge clk);
    in_sig = 32'h2200_0001; @(negedge clk);
    new_sig = 1'b0;
    drain();
    chk("seq3_nstrobes", 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() == 3) begin
      chk("seq3_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd3);
      chk("seq3_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd3);
    end
    chk("seq3_peak", 32'(peak), 32'd2);

    // Fill to full: pops land on the 2nd and 5th push edges, so the
    // 6th push fills the FIFO and the 7th is rejected.
    strobe_cyc.delete();
    new_sig = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_sig = 32'h5200_0100 + 32'(i);
      if (i < 6) sb.push_back('{in_sig, RT_R});
      @(negedge clk);
      if (i == 5) begin
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
      end
      if (i == 6) begin
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
      end
      if (i < 5) chk("ovf_early", 32'(overflow), 32'd0);
    end
    new_sig = 1'b0;
    @(negedge clk);
    chk("ovf_one_cycle", 32'(overflow), 32'd0);
    drain();
    chk("fill_nstrobes", 32'(strobe_cyc.size()), 32'd6);

    // Invalid destination dropped, next entry still sent.
    sb.push_back('{32'h3200_0004, RT_R});
    new_sig = 1'b1;
    in_sig = 32'h9200_0003; @(negedge clk);
    in_sig = 32'h3200_0004; @(negedge clk);
    new_sig = 1'b0;
    exp_drop++;
    drain();
    chk("drop_one", 32'(drop_cnt), 32'(exp_drop));

    // Routing table, one entry at a time.
    for (int i = 0; i < 12; i++) begin
      if (!vt[i].inv) sb.push_back('{vt[i].d, vt[i].rt});
      else exp_drop++;
      drive_push(vt[i].d);
      drain();
      chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(exp_drop));
    end

`ifdef TX_HOLD_EN
    // Head-of-line hold on the right neighbour.
    strobe_cyc.delete();
    hold_r = 1'b1;
    new_sig = 1'b1;
    in_sig = 32'h5200_0201; @(negedge clk);
    in_sig = 32'h2200_0202; @(negedge clk);
    new_sig = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_count", 32'(count), 32'd2);
    chk("hold_nostrobe", 32'(strobe_cyc.size()), 32'd0);
    sb.push_back('{32'h5200_0201, RT_R});
    sb.push_back('{32'h2200_0202, RT_S});
    hold_r = 1'b0;
    drain();
    chk("hold_nstrobes", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() == 2)
      chk("hold_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd3);
`endif

    // Reset during SEND with a second entry queued.
    sb.push_back('{32'h4200_0300, RT_R});
    new_sig = 1'b1;
    in_sig = 32'h4200_0300; @(negedge clk);
    in_sig = 32'h2200_0301; @(negedge clk);
    new_sig = 1'b0;
    chk("rstmid_in_send", 32'(send_r), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_strobe", {29'd0, send_r, send_l, send_s}, 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_out", out_sig, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_count_after", 32'(count), 32'd0);
    chk("rstmid_drop", 32'(drop_cnt), 32'd0);
    chk("rstmid_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
